// File: rtl/deser_pkg.sv
// Shared types for the word deserializer: the two-state frame collection FSM.
package deser_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

endpackage

// File: rtl/word_slot.sv
// One word of the assembled frame: a bits-wide register with load enable,
// cleared by the asynchronous reset.
module word_slot #(
  parameter int bits = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [bits-1:0] d,
  output logic [bits-1:0] q
);

  // Slot storage; holds its value until explicitly loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= {bits{1'b0}};
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/word_deserializer.sv
// Collects length strobed words of bits each into one parallel frame, holds it
// until acknowledged, and flags words that arrive while a frame is held.
module word_deserializer
  import deser_pkg::*;
#(
  parameter int bits   = 4,
  parameter int length = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_in,
  input  logic [bits-1:0]        data_in,
  input  logic                   abort,
  input  logic                   ack,
  output logic [bits*length-1:0] data_out,
  output logic                   valid,
  output logic                   overrun
);

  localparam int CW = $clog2(length + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(length - 1);

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_next_s;
  logic            overrun_r;
  logic            overrun_next_s;
  logic            wr_en_s;
  logic [CW-1:0]   wr_idx_s;
  logic [length-1:0] load_s;

  // State, word counter and sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= COLLECT;
      count_r   <= CNT_ZERO;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      count_r   <= count_next_s;
      overrun_r <= overrun_next_s;
    end
  end

  // Next-state logic; abort outranks a same-cycle strobe while collecting,
  // and ack+strobe in FULL restarts the next frame at slot 0 without loss.
  always_comb begin
    state_next_s   = state_r;
    count_next_s   = count_r;
    overrun_next_s = overrun_r;
    wr_en_s        = 1'b0;
    wr_idx_s       = count_r;
    case (state_r)
      COLLECT: begin
        if (abort) begin
          count_next_s = CNT_ZERO;
        end else if (shift_in) begin
          wr_en_s = 1'b1;
          if (count_r == CNT_LAST) begin
            state_next_s = FULL;
            count_next_s = CNT_ZERO;
          end else begin
            count_next_s = count_r + CNT_ONE;
          end
        end else begin
          count_next_s = count_r;
        end
      end
      FULL: begin
        if (ack) begin
          state_next_s = COLLECT;
          if (shift_in) begin
            wr_en_s      = 1'b1;
            wr_idx_s     = CNT_ZERO;
            count_next_s = CNT_ONE;
          end else begin
            count_next_s = CNT_ZERO;
          end
        end else if (shift_in) begin
          overrun_next_s = 1'b1;
        end else begin
          overrun_next_s = overrun_r;
        end
      end
      default: begin
        state_next_s = COLLECT;
        count_next_s = CNT_ZERO;
      end
    endcase
  end

  // One-hot load enable for the slot being written.
  always_comb begin
    load_s = {length{1'b0}};
    for (int i = 0; i < length; i++) begin
      if (wr_en_s && (wr_idx_s == CW'(i))) begin
        load_s[i] = 1'b1;
      end else begin
        load_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < length; g++) begin : g_slot
    word_slot #(
      .bits(bits)
    ) u_slot (
      .clk  (clk),
      .reset(reset),
      .load (load_s[g]),
      .d    (data_in),
      .q    (data_out[g*bits +: bits])
    );
  end

  assign valid   = (state_r == FULL);
  assign overrun = overrun_r;

endmodule

// File: tb/tb_word_deserializer.sv
// Scoreboard bench for word_deserializer (bits=4, length=4): expected frames are
// queued by the stimulus and checked by a monitor on each rising edge of valid.
module tb_word_deserializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        shift_in = 1'b0;
  logic [3:0]  data_in = 4'h0;
  logic        abort = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] data_out;
  logic        valid;
  logic        overrun;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic        valid_q = 1'b0;

  word_deserializer #(.bits(4), .length(4)) dut (
    .clk(clk), .reset(reset), .shift_in(shift_in), .data_in(data_in),
    .abort(abort), .ack(ack), .data_out(data_out), .valid(valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; the next rising edge samples them.
  task automatic drive(input logic sh, input logic [3:0] d, input logic ab, input logic ak);
    @(negedge clk);
    shift_in = sh;
    data_in  = d;
    abort    = ab;
    ack      = ak;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // Monitor: every new frame presented must match the oldest expected frame.
  always @(negedge clk) begin
    if (valid && !valid_q) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL frame: unexpected frame %h", data_out);
      end else begin
        chk("frame", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
      end
    end
    valid_q <= valid;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    #2;
    chk("reset_valid", {31'h0, valid}, 32'h0);
    chk("reset_overrun", {31'h0, overrun}, 32'h0);
    chk("reset_data", {16'h0, data_out}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back frame 1,2,3,4.
    exp_q.push_back(16'h4321);
    drive(1'b1, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 1'b0, 1'b0);
    drive(1'b1, 4'h3, 1'b0, 1'b0);
    drive(1'b1, 4'h4, 1'b0, 1'b0);
    chk("valid_before_last", {31'h0, valid}, 32'h0);
    idle();
    chk("valid_latency", {31'h0, valid}, 32'h1);
    chk("overrun_clean", {31'h0, overrun}, 32'h0);

    // Abort is ignored while a frame is held.
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    idle();
    chk("abort_in_full", {31'h0, valid}, 32'h1);

    // Ack with simultaneous strobe starts the next frame at slot 0.
    exp_q.push_back(16'h8765);
    drive(1'b1, 4'h5, 1'b0, 1'b1);
    drive(1'b1, 4'h6, 1'b0, 1'b0);
    chk("valid_after_ack", {31'h0, valid}, 32'h0);
    drive(1'b1, 4'h7, 1'b0, 1'b0);
    drive(1'b1, 4'h8, 1'b0, 1'b0);
    idle();
    chk("valid_frame2", {31'h0, valid}, 32'h1);
    chk("overrun_ack_strobe", {31'h0, overrun}, 32'h0);

    // Strobe while held: word dropped, overrun set and sticky across ack.
    drive(1'b1, 4'hA, 1'b0, 1'b0);
    idle();
    chk("overrun_set", {31'h0, overrun}, 32'h1);
    chk("frame_stable", {16'h0, data_out}, 32'h8765);
    chk("valid_held", {31'h0, valid}, 32'h1);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    idle();
    chk("valid_released", {31'h0, valid}, 32'h0);
    chk("overrun_sticky", {31'h0, overrun}, 32'h1);

    // Asynchronous reset mid-frame clears everything immediately.
    drive(1'b1, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 1'b0, 1'b0);
    drive(1'b1, 4'h3, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    shift_in = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_data", {16'h0, data_out}, 32'h0);
    chk("async_overrun", {31'h0, overrun}, 32'h0);
    chk("async_valid", {31'h0, valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(16'h7654);
    drive(1'b1, 4'h4, 1'b0, 1'b0);
    drive(1'b1, 4'h5, 1'b0, 1'b0);
    drive(1'b1, 4'h6, 1'b0, 1'b0);
    drive(1'b1, 4'h7, 1'b0, 1'b0);
    idle();
    chk("valid_after_reset", {31'h0, valid}, 32'h1);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    idle();

    // Abort wins over a same-cycle strobe; ack while collecting is ignored.
    exp_q.push_back(16'hFEDC);
    drive(1'b1, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 1'b0, 1'b0);
    drive(1'b1, 4'h9, 1'b1, 1'b0);
    drive(1'b1, 4'hC, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 4'hD, 1'b0, 1'b0);
    drive(1'b1, 4'hE, 1'b0, 1'b0);
    drive(1'b1, 4'hF, 1'b0, 1'b0);
    idle();
    chk("valid_abort_frame", {31'h0, valid}, 32'h1);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    idle();

    // Gapped strobes assemble the same frame as back-to-back ones.
    exp_q.push_back(16'h4321);
    drive(1'b1, 4'h1, 1'b0, 1'b0);
    idle();
    drive(1'b1, 4'h2, 1'b0, 1'b0);
    idle();
    idle();
    idle();
    drive(1'b1, 4'h3, 1'b0, 1'b0);
    idle();
    idle();
    chk("valid_gap_early", {31'h0, valid}, 32'h0);
    drive(1'b1, 4'h4, 1'b0, 1'b0);
    idle();
    chk("valid_gap", {31'h0, valid}, 32'h1);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    idle();
    idle();

    chk("frames_outstanding", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
